pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 12 +
 rtl/pwm_capture_if.sv | 28 ++
 rtl/pwm_capture_sync_edge_detect.sv | 31 +++
 rtl/pwm_capture.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared PWM width constant and capture FSM state encoding
package pwm_capture_pkg;

    localparam int PWM_BIT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - measurement result bundle from pwm_capture to its consumer
interface pwm_capture_if #(
    parameter int bit_width = 8
);

    logic [bit_width-1:0] high_meas;
    logic [bit_width-1:0] period_meas;
    logic                 meas_valid;
    logic                 timeout;
    logic                 level;

    modport master (
        output high_meas,
        output period_meas,
        output meas_valid,
        output timeout,
        output level
    );

    modport slave (
        input high_meas,
        input period_meas,
        input meas_valid,
        input timeout,
        input level
    );

endinterface

// File: rtl/pwm_capture_sync_edge_detect.sv
// rtl/pwm_capture_sync_edge_detect.sv - two-flop synchronizer plus history flop edge detector
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~hist_q;
    assign fall = ~sync_q & hist_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an asynchronous PWM input
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int bit_width = PWM_BIT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pwm_in,
    input  logic           enable,
    pwm_capture_if.master  meas
);

    localparam logic [bit_width-1:0] CNT_MAX = {bit_width{1'b1}};
    localparam logic [bit_width-1:0] CNT_ONE = bit_width'(1);

    logic sync;
    logic rise;
    logic fall;

    pwm_state_e           state_q,  state_d;
    logic [bit_width-1:0] cnt_q,    cnt_d;
    logic [bit_width-1:0] hi_tmp_q, hi_tmp_d;
    logic [bit_width-1:0] high_q,   high_d;
    logic [bit_width-1:0] period_q, period_d;
    logic                 valid_q,  valid_d;
    logic                 timeout_q, timeout_d;
    logic                 level_q;
    logic [bit_width-1:0] cnt_inc;

    sync_edge_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .sync  (sync),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increment so a fall landing on the final count cannot wrap.
    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_tmp_q  <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_tmp_q  <= hi_tmp_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            level_q   <= sync;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_tmp_d  = hi_tmp_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    // A rise here means the fall was lost; the whole span counts as high.
                    if (rise) begin
                        high_d    = cnt_q;
                        period_d  = cnt_q;
                        cnt_d     = CNT_ONE;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                    end else if (fall) begin
                        state_d  = LOW;
                        hi_tmp_d = cnt_q;
                        cnt_d    = cnt_inc;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d   = HIGH;
                        high_d    = hi_tmp_q;
                        period_d  = cnt_q;
                        cnt_d     = CNT_ONE;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign meas.high_meas   = high_q;
    assign meas.period_meas = period_q;
    assign meas.meas_valid  = valid_q;
    assign meas.timeout     = timeout_q;
    assign meas.level       = level_q;

endmodule
